update_dispatcher: RTL and testbench

Ingress stage directly upstream of the arbitrage container. Accepts edge-weight updates (source vertex, destination vertex, weight) from the host write port, buffers them in a small FIFO, and feeds them one at a time to the container. Each update gets a one-cycle `container_reset` pulse with `u_src`/`u_dst`/`u_e` held stable, then the block waits for `container_done` before issuing the next. It also owns the Bellman source-vertex register and exposes status and error counters to the host.

---
 rtl/hft_pkg.sv | 28 ++
 rtl/update_fifo.sv | 48 ++++
 rtl/update_dispatcher.sv | 135 +++++++++++++
 tb/tb_update_dispatcher.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hft_pkg.sv
// Types shared by the arbitrage ingress path: vertex/weight widths, the
// update record and the dispatcher state encoding.
package hft_pkg;

    localparam int PRED_W   = 5;
    localparam int WEIGHT_W = 32;

    typedef logic [PRED_W-1:0]   vert_t;
    typedef logic [WEIGHT_W-1:0] weight_t;

    typedef struct packed {
        vert_t   src;
        vert_t   dst;
        weight_t e;
    } update_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PULSE,
        ST_WAIT
    } disp_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/update_fifo.sv
// Single-clock first-word-fall-through FIFO of update records; pointers carry
// one extra wrap bit so full and empty are distinguishable.
module update_fifo
    import hft_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clk,
    input  logic    reset_n,
    input  logic    push,
    input  logic    pop,
    input  update_t din,
    output update_t dout,
    output logic    full,
    output logic    empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    update_t     mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/update_dispatcher.sv
// Buffers host edge-weight updates and hands them one at a time to the
// arbitrage container; also owns the Bellman source register and error counters.
module update_dispatcher
    import hft_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [PRED_W-1:0]   wr_src,
    input  logic [PRED_W-1:0]   wr_dst,
    input  logic [WEIGHT_W-1:0] wr_e,
    input  logic                cfg_src_we,
    input  logic [PRED_W-1:0]   cfg_src,
    output logic                container_reset,
    output logic [PRED_W-1:0]   src,
    output logic [PRED_W-1:0]   u_src,
    output logic [PRED_W-1:0]   u_dst,
    output logic [WEIGHT_W-1:0] u_e,
    input  logic                container_done,
    output logic                busy,
    output logic [7:0]          dropped,
    output logic [7:0]          timeouts
);

    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    disp_state_t       state_q, state_d;
    logic [WD_W-1:0]   wdog_q;
    logic              timeout_hit;
    logic              self_loop, push, pop;
    logic              fifo_full, fifo_empty;
    update_t           fifo_din, fifo_dout;
    logic              src_pend;
    logic [PRED_W-1:0] src_pend_val;

    assign self_loop = (wr_src == wr_dst);
    assign push      = wr_valid && wr_ready && !self_loop;
    assign pop       = (state_q == ST_LOAD);
    assign fifo_din  = '{src: wr_src, dst: wr_dst, e: wr_e};
    // Full comes straight from pointer flops, never from wr_valid.
    assign wr_ready  = !fifo_full;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;

    update_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (fifo_din),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        unique case (state_q)
            ST_IDLE:  if (!fifo_empty) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_PULSE;
            ST_PULSE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (container_done) begin
                    state_d = ST_IDLE;
                end else if (wdog_q == WD_LAST) begin
                    timeout_hit = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            container_reset <= 1'b0;
            wdog_q          <= '0;
        end else begin
            state_q         <= state_d;
            // Registered so the container sees a clean single-cycle pulse.
            container_reset <= (state_d == ST_PULSE);
            if (state_q == ST_PULSE)     wdog_q <= '0;
            else if (state_q == ST_WAIT) wdog_q <= wdog_q + WD_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            u_src <= '0;
            u_dst <= '0;
            u_e   <= '0;
        end else if (pop) begin
            u_src <= fifo_dout.src;
            u_dst <= fifo_dout.dst;
            u_e   <= fifo_dout.e;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dropped  <= '0;
            timeouts <= '0;
        end else begin
            if (wr_valid && (!wr_ready || self_loop)) dropped <= sat_inc8(dropped);
            if (timeout_hit) timeouts <= sat_inc8(timeouts);
        end
    end

    // Source writes outside IDLE are parked and land on the edge that re-enters
    // IDLE; a write arriving on that same edge overrides the parked value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src          <= '0;
            src_pend     <= 1'b0;
            src_pend_val <= '0;
        end else if (state_q == ST_IDLE) begin
            if (cfg_src_we) src <= cfg_src;
        end else if (state_d == ST_IDLE) begin
            if (cfg_src_we)    src <= cfg_src;
            else if (src_pend) src <= src_pend_val;
            src_pend <= 1'b0;
        end else if (cfg_src_we) begin
            src_pend     <= 1'b1;
            src_pend_val <= cfg_src;
        end
    end

endmodule

// File: tb/tb_update_dispatcher.sv
// Self-checking bench for update_dispatcher: scoreboard of expected updates
// compared on each container_reset pulse, plus directed corner sequences.
module tb_update_dispatcher;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_src, wr_dst;
    logic [31:0] wr_e;
    logic        cfg_src_we;
    logic [4:0]  cfg_src;
    logic        container_reset;
    logic [4:0]  src, u_src, u_dst;
    logic [31:0] u_e;
    logic        container_done;
    logic        busy;
    logic [7:0]  dropped, timeouts;

    update_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_src(wr_src), .wr_dst(wr_dst), .wr_e(wr_e),
        .cfg_src_we(cfg_src_we), .cfg_src(cfg_src),
        .container_reset(container_reset), .src(src),
        .u_src(u_src), .u_dst(u_dst), .u_e(u_e),
        .container_done(container_done), .busy(busy),
        .dropped(dropped), .timeouts(timeouts)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  s;
        logic [4:0]  d;
        logic [31:0] e;
    } upd_t;

    typedef struct {
        logic [4:0]  s;
        logic [4:0]  d;
        logic [31:0] e;
        logic        exp_ready;
    } vec_t;

    upd_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   pulses = 0;

    // Container model: clears done on the pulse, raises it 'delay' cycles later if enabled.
    logic done_en = 1'b0;
    int   delay   = 10;
    logic armed   = 1'b0;
    int   cnt     = 0;
    logic crst_prev = 1'b0;

    always @(negedge clk) begin
        if (container_reset) begin
            upd_t x;
            pulses++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL pulse_unexpected: pulse with u=(%0d,%0d,%0d), expected none", u_src, u_dst, u_e);
            end else begin
                x = sb.pop_front();
                if (crst_prev || u_src !== x.s || u_dst !== x.d || u_e !== x.e) begin
                    bad++;
                    $display("FAIL pulse_update: got (%0d,%0d,%0d) width_err=%0d, expected (%0d,%0d,%0d)",
                             u_src, u_dst, u_e, crst_prev, x.s, x.d, x.e);
                end
            end
            container_done = 1'b0;
            armed = 1'b1;
            cnt = 0;
        end else if (armed) begin
            cnt++;
            if (done_en && cnt >= delay) begin
                container_done = 1'b1;
                armed = 1'b0;
            end
        end
        crst_prev = container_reset;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input logic [4:0] s, input logic [4:0] d, input logic [31:0] e, input logic accept);
        upd_t x;
        wr_src = s; wr_dst = d; wr_e = e; wr_valid = 1'b1;
        if (accept) begin
            x.s = s; x.d = d; x.e = e;
            sb.push_back(x);
        end
        step();
        wr_valid = 1'b0;
    endtask

    task automatic wait_pulse(input string name, input int maxc);
        int n = 0;
        while (!container_reset && n < maxc) begin
            step();
            n++;
        end
        chk(name, {31'd0, container_reset}, 32'd1);
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int n = 0;
        while (busy && n < maxc) begin
            step();
            n++;
        end
        chk(name, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vecs [9];
        int   exp_drop;
        int   p0, to0;
        logic [4:0] s0;

        for (int i = 0; i < 9; i++) begin
            vecs[i].s = (i < 8) ? 5'(i) : 5'd20;
            vecs[i].d = (i < 8) ? 5'(i + 8) : 5'd21;
            vecs[i].e = 32'(1000 + i);
            vecs[i].exp_ready = (i < DEPTH);
        end

        reset_n = 1'b0; wr_valid = 1'b0; wr_src = '0; wr_dst = '0; wr_e = '0;
        cfg_src_we = 1'b0; cfg_src = '0; container_done = 1'b0;
        exp_drop = 0;
        repeat (3) step();
        reset_n = 1'b1;
        step();

        // Reset state
        chk("rst_wr_ready", {31'd0, wr_ready}, 1);
        chk("rst_crst", {31'd0, container_reset}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_src", {27'd0, src}, 0);
        chk("rst_u_e", u_e, 0);
        chk("rst_dropped", {24'd0, dropped}, 0);
        chk("rst_timeouts", {24'd0, timeouts}, 0);

        // Single update and two-cycle latency to the pulse
        done_en = 1'b1; delay = 10;
        wr(5'd3, 5'd7, 32'd100, 1'b1);
        chk("single_busy", {31'd0, busy}, 1);
        step();
        chk("single_load_no_pulse", {31'd0, container_reset}, 0);
        step();
        chk("single_pulse_at_2", {31'd0, container_reset}, 1);
        begin
            int n = 0;
            while (!container_done && n < 40) begin step(); n++; end
        end
        chk("single_done_seen", {31'd0, container_done}, 1);
        chk("single_idle_after_done", {31'd0, busy}, 0);
        chk("single_u_src_held", {27'd0, u_src}, 3);
        chk("single_u_e_held", u_e, 100);

        // Self-loop is dropped, nothing enqueued
        p0 = pulses;
        wr(5'd4, 5'd4, 32'd5, 1'b0);
        exp_drop++;
        chk("selfloop_busy", {31'd0, busy}, 0);
        repeat (4) step();
        chk("selfloop_no_pulse", pulses, p0);
        chk("selfloop_dropped", {24'd0, dropped}, exp_drop);

        // Fill and overflow while the container is stalled in WAIT
        done_en = 1'b0; delay = 2;
        p0 = pulses;
        wr(5'd30, 5'd31, 32'd77, 1'b1);
        wait_pulse("fill_first_pulse", 10);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("fill_ready_%0d", i), {31'd0, wr_ready}, {31'd0, vecs[i].exp_ready});
            wr(vecs[i].s, vecs[i].d, vecs[i].e, vecs[i].exp_ready);
            if (!vecs[i].exp_ready) exp_drop++;
        end
        chk("fill_dropped", {24'd0, dropped}, exp_drop);
        chk("fill_timeouts_none", {24'd0, timeouts}, 0);
        done_en = 1'b1;
        wait_idle("fill_drain_idle", 300);
        chk("fill_drain_sb_empty", sb.size(), 0);
        chk("fill_pulse_count", pulses - p0, 9);

        // Watchdog expiry, then next queued update goes out
        done_en = 1'b0;
        to0 = timeouts;
        wr(5'd1, 5'd2, 32'd11, 1'b1);
        wr(5'd5, 5'd6, 32'd22, 1'b1);
        wait_pulse("to_first_pulse", 10);
        repeat (TIMEOUT) step();
        chk("to_not_yet", {24'd0, timeouts}, to0);
        step();
        chk("to_expired", {24'd0, timeouts}, to0 + 1);
        chk("to_busy_queued", {31'd0, busy}, 1);
        step(); step();
        chk("to_next_pulse", {31'd0, container_reset}, 1);
        wait_idle("to_second_idle", 60);
        chk("to_second_expired", {24'd0, timeouts}, to0 + 2);

        // Source register: direct in IDLE, deferred during WAIT
        cfg_src = 5'd2; cfg_src_we = 1'b1;
        step();
        cfg_src_we = 1'b0;
        chk("src_idle_write", {27'd0, src}, 2);
        s0 = src;
        done_en = 1'b1; delay = 6;
        wr(5'd8, 5'd9, 32'd33, 1'b1);
        wait_pulse("src_pulse", 10);
        step();
        cfg_src = 5'd9; cfg_src_we = 1'b1;
        step();
        cfg_src_we = 1'b0; cfg_src = 5'd0;
        chk("src_deferred_hold", {27'd0, src}, {27'd0, s0});
        wait_idle("src_idle", 40);
        chk("src_applied_on_idle", {27'd0, src}, 9);

        // Asynchronous reset mid-WAIT with three entries queued
        done_en = 1'b0;
        wr(5'd10, 5'd11, 32'd44, 1'b1);
        wait_pulse("rst_mid_pulse", 10);
        wr(5'd12, 5'd13, 32'd1, 1'b1);
        wr(5'd14, 5'd15, 32'd2, 1'b1);
        wr(5'd16, 5'd17, 32'd3, 1'b1);
        #1 reset_n = 1'b0;
        #1;
        chk("rstmid_busy", {31'd0, busy}, 0);
        chk("rstmid_wr_ready", {31'd0, wr_ready}, 1);
        chk("rstmid_src", {27'd0, src}, 0);
        chk("rstmid_u_src", {27'd0, u_src}, 0);
        chk("rstmid_dropped", {24'd0, dropped}, 0);
        chk("rstmid_timeouts", {24'd0, timeouts}, 0);
        sb.delete();
        step(); step();
        reset_n = 1'b1;
        p0 = pulses;
        repeat (25) step();
        chk("rstmid_no_pulse", pulses, p0);
        chk("rstmid_still_idle", {31'd0, busy}, 0);
        done_en = 1'b1;
        wr(5'd13, 5'd14, 32'd55, 1'b1);
        wait_idle("rstmid_new_write", 40);
        chk("rstmid_one_pulse", pulses, p0 + 1);
        chk("final_sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
